cache_control_nway: RTL and testbench
=====================================

# cache_control_nway

Parametrised write-back, write-allocate cache controller for an N-way set-associative cache. It owns all per-set metadata (valid, dirty, tag, tree-PLRU bits), performs hit detection and victim selection, and sequences physical-memory writeback and fill. It drives way-select and data-array write controls for an external data array. It sits between the CPU-side memory port and the physical-memory (pmem) port, and replaces the fixed two-state-miss controller.

## Interface
- WAYS, 2: associativity; power of two, 2..8
- SETS_LOG2, 3: log2 of set count
- TAG_W, 9: tag width in bits
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request
- mem_write  in  1  CPU write request
- mem_tag  in  TAG_W  request tag
- mem_set  in  SETS_LOG2  request set index
- mem_resp  out  1  request complete
- way_sel  out  WAYS  one-hot way for the external data array (hit way or latched victim)
- data_write  out  1  data-array write enable
- data_src_sel  out  1  0 = fill data from pmem, 1 = merged CPU write data
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_addr_sel  out  1  0 = {mem_tag, mem_set}, 1 = {wb_tag, mem_set}
- wb_tag  out  TAG_W  tag of the latched victim line
- pmem_resp  in  1  pmem transfer complete
- hit_count, miss_count  out  32 each  present only with CACHE_PERF_CTR_EN

## Operation
- States: IDLE, WRITEBACK, FILL.
- req = mem_read | mem_write. When both are high, the request is treated as a write.
- hit = valid & tag match in any way of mem_set. At most one way may match.
- IDLE, req & hit:
  - mem_resp = 1 and way_sel = hit way.
  - The PLRU bits are updated.
  - On a write, also assert data_write and data_src_sel = 1, and set the way's dirty bit.
- IDLE, req & !hit:
  - Choose the victim: the lowest-index invalid way, otherwise the PLRU victim. Latch it into a register.
  - Go to WRITEBACK if the victim is valid & dirty, otherwise go to FILL.
- WRITEBACK:
  - pmem_write = 1, pmem_addr_sel = 1, way_sel = victim.
  - On pmem_resp: clear the victim's dirty bit and go to FILL.
- FILL:
  - pmem_read = 1, way_sel = victim, data_src_sel = 0.
  - On pmem_resp: data_write = 1, write the victim tag = mem_tag, set valid = 1 and dirty = 0, then go to IDLE.
  - The request then hits in the following cycle. A write sets dirty on that hit.
- Tree-PLRU uses WAYS-1 bits per set.
  - Node bit 0 points to the lower half and 1 to the upper half. The victim is found by following the bits from the root.
  - On a hit to way w, every node on w's path is set to point away from w.
- The requester holds mem_read, mem_write, mem_tag and mem_set stable until mem_resp. An in-progress miss is never aborted.
- mem_resp is a single-cycle pulse per request.

## Timing
- Hit: mem_resp in the same cycle as the request (combinational from registered metadata).
- Clean miss: FILL is entered on the next edge. mem_resp comes 1 cycle after the pmem_resp cycle.
- Dirty miss: WRITEBACK, then FILL, then IDLE. pmem_write and pmem_read are never asserted in the same cycle.
- pmem_read and pmem_write are held continuously until the pmem_resp cycle and drop on the following edge.
- Reset, including mid-miss:
  - Effect: state returns to IDLE; all valid, dirty and PLRU bits clear; the latched victim returns to way 0.
  - Outputs: mem_resp, data_write, pmem_read and pmem_write are 0. way_sel is 0 while no request is present. wb_tag is 0, and the counters are 0.
  - A pmem_resp arriving during reset is ignored.

## Configuration
- CACHE_PERF_CTR_EN defined:
  - hit_count increments once per IDLE hit response.
  - miss_count increments once per IDLE→miss transition.
  - Both wrap at 2^32 and are cleared by rst.
- CACHE_PERF_CTR_EN undefined: the counter ports and logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then read tag 0x012 set 3: FILL is entered, pmem_read is held 5 cycles until pmem_resp; the next cycle gives mem_resp with way_sel = 4'b0001.
- Fill ways 0..3 of set 3 with tags 0x010..0x013 by reads, then read tag 0x020: the PLRU victim is way 0, pmem_read asserts, and pmem_write never asserts.
- Write-hit tag 0x011 in set 3, then force eviction of way 1: WRITEBACK with wb_tag = 0x011 and pmem_addr_sel = 1, then FILL, then mem_resp.
- mem_read and mem_write both high on a hit: data_write = 1, the dirty bit is set, and mem_resp lasts exactly 1 cycle.
- Assert rst during FILL before pmem_resp: the next cycle has pmem_read = 0 and state IDLE, and a subsequent read of the same tag misses.
- With CACHE_PERF_CTR_EN defined: 3 misses then 5 hits give miss_count = 3 and hit_count = 5.

Source files
------------

// File: rtl/cache_control_nway.sv
// N-way set-associative write-back / write-allocate cache controller with tree-PLRU replacement.
// Defining CACHE_PERF_CTR_EN adds the hit_count / miss_count performance counters.
module cache_control_nway #(
   parameter int WAYS      = 2,
   parameter int SETS_LOG2 = 3,
   parameter int TAG_W     = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [TAG_W-1:0]     mem_tag,
   input  logic [SETS_LOG2-1:0] mem_set,
   output logic                 mem_resp,
   output logic [WAYS-1:0]      way_sel,
   output logic                 data_write,
   output logic                 data_src_sel,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic                 pmem_addr_sel,
   output logic [TAG_W-1:0]     wb_tag,
`ifdef CACHE_PERF_CTR_EN
   input  logic                 pmem_resp,
   output logic [31:0]          hit_count,
   output logic [31:0]          miss_count
`else
   input  logic                 pmem_resp
`endif
);

   localparam int WAY_W = $clog2(WAYS);
   localparam int SETS  = 1 << SETS_LOG2;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      FILL
   } state_t;

   state_t state_q, state_d;

   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  dirty_q [SETS];
   logic [WAYS-2:0]  plru_q  [SETS];
   logic [TAG_W-1:0] tag_q   [SETS][WAYS];

   logic [WAY_W-1:0] victim_q;
   logic [TAG_W-1:0] wb_tag_q;

   logic             req;
   logic [WAYS-1:0]  hitVec;
   logic             hit;
   logic [WAY_W-1:0] hitWay;
   logic             freeAny;
   logic [WAY_W-1:0] freeWay;
   logic [WAY_W-1:0] victimSel;
   logic             idleHit;
   logic             idleMiss;

   // Nodes are heap-ordered: node n has children 2n+1 (lower half) and 2n+2 (upper half).
   function automatic logic [WAY_W-1:0] plruVictim(input logic [WAYS-2:0] bits);
      logic [WAY_W-1:0] v;
      int               node;
      v    = '0;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         v[WAY_W-1-l] = bits[node];
         node         = 2 * node + (bits[node] ? 2 : 1);
      end
      return v;
   endfunction

   function automatic logic [WAYS-2:0] plruUpdate(input logic [WAYS-2:0] bits,
                                                  input logic [WAY_W-1:0] way);
      logic [WAYS-2:0] r;
      logic            d;
      int              node;
      r    = bits;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         d       = way[WAY_W-1-l];
         r[node] = ~d;
         node    = 2 * node + (d ? 2 : 1);
      end
      return r;
   endfunction

   function automatic logic [WAYS-1:0] oneHot(input logic [WAY_W-1:0] w);
      logic [WAYS-1:0] r;
      r    = '0;
      r[w] = 1'b1;
      return r;
   endfunction

   assign req = mem_read | mem_write;

   always_comb begin
      hitVec = '0;
      for (int w = 0; w < WAYS; w++) begin
         hitVec[w] = valid_q[mem_set][w] && (tag_q[mem_set][w] == mem_tag);
      end
   end

   assign hit = |hitVec;

   // Scanning downwards leaves the lowest-index candidate in both encoders.
   always_comb begin
      hitWay  = '0;
      freeAny = 1'b0;
      freeWay = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hitVec[w]) begin
            hitWay = WAY_W'(w);
         end
         if (!valid_q[mem_set][w]) begin
            freeAny = 1'b1;
            freeWay = WAY_W'(w);
         end
      end
   end

   assign victimSel = freeAny ? freeWay : plruVictim(plru_q[mem_set]);
   assign idleHit   = (state_q == IDLE) && req && hit;
   assign idleMiss  = (state_q == IDLE) && req && !hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs are forced quiet while reset is held so an abandoned miss never leaks a pmem request.
   always_comb begin
      state_d       = state_q;
      mem_resp      = 1'b0;
      way_sel       = '0;
      data_write    = 1'b0;
      data_src_sel  = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && hit) begin
               mem_resp = 1'b1;
               way_sel  = oneHot(hitWay);
               if (mem_write) begin
                  data_write   = 1'b1;
                  data_src_sel = 1'b1;
               end
            end else if (req) begin
               if (valid_q[mem_set][victimSel] && dirty_q[mem_set][victimSel]) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = FILL;
               end
            end
         end
         WRITEBACK: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            way_sel       = oneHot(victim_q);
            if (pmem_resp) begin
               state_d = FILL;
            end
         end
         FILL: begin
            pmem_read = 1'b1;
            way_sel   = oneHot(victim_q);
            if (pmem_resp) begin
               data_write = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (rst) begin
         state_d       = IDLE;
         mem_resp      = 1'b0;
         way_sel       = '0;
         data_write    = 1'b0;
         data_src_sel  = 1'b0;
         pmem_read     = 1'b0;
         pmem_write    = 1'b0;
         pmem_addr_sel = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         victim_q <= '0;
         wb_tag_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         if (idleHit) begin
            plru_q[mem_set] <= plruUpdate(plru_q[mem_set], hitWay);
            if (mem_write) begin
               dirty_q[mem_set][hitWay] <= 1'b1;
            end
         end
         if (idleMiss) begin
            victim_q <= victimSel;
            wb_tag_q <= tag_q[mem_set][victimSel];
         end
         if (state_q == WRITEBACK && pmem_resp) begin
            dirty_q[mem_set][victim_q] <= 1'b0;
         end
         if (state_q == FILL && pmem_resp) begin
            valid_q[mem_set][victim_q] <= 1'b1;
            dirty_q[mem_set][victim_q] <= 1'b0;
         end
      end
   end

   // Tags need no reset: a way's tag is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (!rst && state_q == FILL && pmem_resp) begin
         tag_q[mem_set][victim_q] <= mem_tag;
      end
   end

   assign wb_tag = wb_tag_q;

`ifdef CACHE_PERF_CTR_EN
   logic [31:0] hit_count_q;
   logic [31:0] miss_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         if (idleHit) begin
            hit_count_q <= hit_count_q + 32'd1;
         end
         if (idleMiss) begin
            miss_count_q <= miss_count_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_control_nway.sv
// Scoreboard bench for cache_control_nway (4 ways, 8 sets, 9-bit tags).
// Counter checks compile in only when CACHE_PERF_CTR_EN is defined.
module tb_cache_control_nway;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_read;
   logic       mem_write;
   logic [8:0] mem_tag;
   logic [2:0] mem_set;
   logic       mem_resp;
   logic [3:0] way_sel;
   logic       data_write;
   logic       data_src_sel;
   logic       pmem_read;
   logic       pmem_write;
   logic       pmem_addr_sel;
   logic [8:0] wb_tag;
   logic       pmem_resp;
`ifdef CACHE_PERF_CTR_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   cache_control_nway #(
      .WAYS(4),
      .SETS_LOG2(3),
      .TAG_W(9)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_tag(mem_tag),
      .mem_set(mem_set),
      .mem_resp(mem_resp),
      .way_sel(way_sel),
      .data_write(data_write),
      .data_src_sel(data_src_sel),
      .pmem_read(pmem_read),
      .pmem_write(pmem_write),
      .pmem_addr_sel(pmem_addr_sel),
      .wb_tag(wb_tag),
`ifdef CACHE_PERF_CTR_EN
      .pmem_resp(pmem_resp),
      .hit_count(hit_count),
      .miss_count(miss_count)
`else
      .pmem_resp(pmem_resp)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       isMiss;
      logic       isWb;
      logic [1:0] way;
      logic [8:0] wbTag;
      logic       wr;
   } exp_t;

   exp_t expQ[$];

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model: tree bits are [0]=root, [1]=ways 0/1 pair, [2]=ways 2/3 pair.
   logic       mValid [8][4];
   logic       mDirty [8][4];
   logic [8:0] mTag   [8][4];
   logic [2:0] mPlru  [8];
   int         expHits;
   int         expMisses;

   logic [3:0] lastFillWay;
   logic [8:0] lastWbTag;
   logic       lastSawWb;
   logic       lastSawRead;

   task automatic modelReset();
      for (int s = 0; s < 8; s++) begin
         mPlru[s] = 3'b000;
         for (int w = 0; w < 4; w++) begin
            mValid[s][w] = 1'b0;
            mDirty[s][w] = 1'b0;
            mTag[s][w]   = 9'h000;
         end
      end
      expHits   = 0;
      expMisses = 0;
   endtask

   function automatic logic [1:0] modelVictim(input logic [2:0] s);
      for (int w = 0; w < 4; w++) begin
         if (!mValid[s][w]) return 2'(w);
      end
      if (mPlru[s][0] == 1'b0) return mPlru[s][1] ? 2'd1 : 2'd0;
      return mPlru[s][2] ? 2'd3 : 2'd2;
   endfunction

   task automatic modelTouch(input logic [2:0] s, input logic [1:0] w);
      case (w)
         2'd0: begin mPlru[s][0] = 1'b1; mPlru[s][1] = 1'b1; end
         2'd1: begin mPlru[s][0] = 1'b1; mPlru[s][1] = 1'b0; end
         2'd2: begin mPlru[s][0] = 1'b0; mPlru[s][2] = 1'b1; end
         default: begin mPlru[s][0] = 1'b0; mPlru[s][2] = 1'b0; end
      endcase
   endtask

   task automatic applyReset();
      rst       = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_tag   = '0;
      mem_set   = '0;
      pmem_resp = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      modelReset();
   endtask

   // Drives one request to completion; pmem_resp is given on the lat-th cycle of each pmem phase.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [8:0] tag,
                                input logic [2:0] set, input int lat);
      exp_t       e;
      exp_t       got;
      int         hw;
      logic [1:0] v;
      int         rdCnt, wrCnt, firstRd, lastRd, firstWr, lastWr, respCyc;
      bit         done;
      hw = -1;
      for (int w = 0; w < 4; w++) begin
         if (mValid[set][w] && mTag[set][w] == tag) hw = w;
      end
      e.wr = wr;
      if (hw < 0) begin
         v             = modelVictim(set);
         e.isMiss      = 1'b1;
         e.isWb        = mValid[set][v] && mDirty[set][v];
         e.wbTag       = mTag[set][v];
         e.way         = v;
         mTag[set][v]  = tag;
         mValid[set][v] = 1'b1;
         mDirty[set][v] = 1'b0;
         expMisses++;
      end else begin
         e.isMiss = 1'b0;
         e.isWb   = 1'b0;
         e.wbTag  = '0;
         e.way    = hw[1:0];
      end
      modelTouch(set, e.way);
      if (wr) mDirty[set][e.way] = 1'b1;
      expHits++;
      expQ.push_back(e);

      mem_read  = rd;
      mem_write = wr;
      mem_tag   = tag;
      mem_set   = set;
      rdCnt = 0; wrCnt = 0; firstRd = -1; lastRd = -1; firstWr = -1; lastWr = -1; respCyc = -1;
      done = 1'b0;
      lastSawWb   = 1'b0;
      lastSawRead = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         testsRun++;
         if (pmem_read && pmem_write) begin
            testsFailed++;
            $display("[TB] FAIL pmem_overlap: read=%0b write=%0b, required not both", pmem_read, pmem_write);
         end
         if (pmem_write) begin
            if (firstWr < 0) firstWr = cyc;
            lastWr    = cyc;
            wrCnt++;
            lastSawWb = 1'b1;
            lastWbTag = wb_tag;
            testsRun++;
            if (pmem_addr_sel !== 1'b1 || way_sel !== (4'b0001 << expQ[0].way) || wb_tag !== expQ[0].wbTag) begin
               testsFailed++;
               $display("[TB] FAIL writeback_ctrl: addr_sel=%0b way_sel=%b wb_tag=%h, required 1 %b %h",
                        pmem_addr_sel, way_sel, wb_tag, 4'b0001 << expQ[0].way, expQ[0].wbTag);
            end
            if (wrCnt == lat) pmem_resp = 1'b1;
         end else if (pmem_read) begin
            if (firstRd < 0) firstRd = cyc;
            lastRd      = cyc;
            rdCnt++;
            lastSawRead = 1'b1;
            lastFillWay = way_sel;
            testsRun++;
            if (pmem_addr_sel !== 1'b0 || data_src_sel !== 1'b0 || way_sel !== (4'b0001 << expQ[0].way)) begin
               testsFailed++;
               $display("[TB] FAIL fill_ctrl: addr_sel=%0b src_sel=%0b way_sel=%b, required 0 0 %b",
                        pmem_addr_sel, data_src_sel, way_sel, 4'b0001 << expQ[0].way);
            end
            if (rdCnt == lat) begin
               pmem_resp = 1'b1;
               #1;
               testsRun++;
               if (data_write !== 1'b1 || mem_resp !== 1'b0) begin
                  testsFailed++;
                  $display("[TB] FAIL fill_write: data_write=%0b mem_resp=%0b, required 1 0", data_write, mem_resp);
               end
            end
         end
         if (mem_resp) begin
            got     = expQ.pop_front();
            respCyc = cyc;
            done    = 1'b1;
            testsRun++;
            if (way_sel !== (4'b0001 << got.way) || data_write !== got.wr || (got.wr && data_src_sel !== 1'b1)) begin
               testsFailed++;
               $display("[TB] FAIL resp_ctrl: way_sel=%b data_write=%0b src_sel=%0b, required %b %0b %0b",
                        way_sel, data_write, data_src_sel, 4'b0001 << got.way, got.wr, got.wr);
            end
            testsRun++;
            if ((firstRd >= 0) !== got.isMiss || (firstWr >= 0) !== got.isWb) begin
               testsFailed++;
               $display("[TB] FAIL miss_path: fill=%0b writeback=%0b, required %0b %0b",
                        firstRd >= 0, firstWr >= 0, got.isMiss, got.isWb);
            end
            testsRun++;
            if (got.isMiss &&
                (respCyc != lastRd + 1 || rdCnt != lat ||
                 (got.isWb ? (firstWr != 1 || wrCnt != lat || firstRd != lastWr + 1) : (firstRd != 1)))) begin
               testsFailed++;
               $display("[TB] FAIL miss_timing: firstWr=%0d wrCnt=%0d firstRd=%0d rdCnt=%0d resp=%0d, lat %0d",
                        firstWr, wrCnt, firstRd, rdCnt, respCyc, lat);
            end else if (!got.isMiss && respCyc != 0) begin
               testsFailed++;
               $display("[TB] FAIL hit_latency: resp cycle=%0d, required 0", respCyc);
            end
         end
         @(posedge clk);
         #1 pmem_resp = 1'b0;
      end
      if (!done) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL resp_timeout: no mem_resp for tag %h set %0d within 200 cycles", tag, set);
         if (expQ.size() > 0) void'(expQ.pop_front());
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      testsRun++;
      if (mem_resp !== 1'b0 || way_sel !== 4'b0000) begin
         testsFailed++;
         $display("[TB] FAIL resp_pulse: mem_resp=%0b way_sel=%b after request drop, required 0 0000", mem_resp, way_sel);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_tag   = '0;
      mem_set   = '0;
      pmem_resp = 1'b0;
      repeat (2) @(negedge clk);
      testsRun++;
      if (mem_resp !== 1'b0 || data_write !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 ||
          way_sel !== 4'b0000 || wb_tag !== 9'h000) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs: resp=%0b dw=%0b pr=%0b pw=%0b way=%b wb_tag=%h, required all 0",
                  mem_resp, data_write, pmem_read, pmem_write, way_sel, wb_tag);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      modelReset();
      @(negedge clk);
      testsRun++;
      if (mem_resp !== 1'b0 || way_sel !== 4'b0000 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL idle_after_reset: resp=%0b way=%b pr=%0b pw=%0b, required 0", mem_resp, way_sel, pmem_read, pmem_write);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_clean_fill();
      applyReset();
      applyStimulus(1'b1, 1'b0, 9'h012, 3'd3, 5);
      testsRun++;
      if (lastFillWay !== 4'b0001 || lastSawWb !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL first_fill: way_sel=%b writeback=%0b, required 0001 0", lastFillWay, lastSawWb);
      end
      applyStimulus(1'b1, 1'b0, 9'h012, 3'd3, 5);
   endtask

   task automatic test_plru_victim();
      applyReset();
      for (int t = 0; t < 4; t++) begin
         applyStimulus(1'b1, 1'b0, 9'h010 + 9'(t), 3'd3, 2);
      end
      applyStimulus(1'b1, 1'b0, 9'h020, 3'd3, 3);
      testsRun++;
      if (lastFillWay !== 4'b0001 || lastSawWb !== 1'b0 || lastSawRead !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL plru_victim: way_sel=%b writeback=%0b fill=%0b, required 0001 0 1",
                  lastFillWay, lastSawWb, lastSawRead);
      end
   endtask

   task automatic test_dirty_writeback();
      applyStimulus(1'b0, 1'b1, 9'h011, 3'd3, 2);
      for (int t = 0; t < 8; t++) begin
         if (modelVictim(3'd3) == 2'd1) break;
         applyStimulus(1'b1, 1'b0, 9'h021 + 9'(t), 3'd3, 2);
      end
      applyStimulus(1'b1, 1'b0, 9'h030, 3'd3, 4);
      testsRun++;
      if (lastSawWb !== 1'b1 || lastWbTag !== 9'h011 || lastFillWay !== 4'b0010) begin
         testsFailed++;
         $display("[TB] FAIL dirty_evict: writeback=%0b wb_tag=%h fill way=%b, required 1 011 0010",
                  lastSawWb, lastWbTag, lastFillWay);
      end
   endtask

   task automatic test_read_write_both();
      applyStimulus(1'b1, 1'b0, 9'h040, 3'd5, 2);
      applyStimulus(1'b1, 1'b1, 9'h040, 3'd5, 2);
      for (int t = 1; t < 4; t++) begin
         applyStimulus(1'b1, 1'b0, 9'h040 + 9'(t), 3'd5, 1);
      end
      applyStimulus(1'b1, 1'b0, 9'h044, 3'd5, 2);
      testsRun++;
      if (lastSawWb !== 1'b1 || lastWbTag !== 9'h040) begin
         testsFailed++;
         $display("[TB] FAIL rw_dirty: writeback=%0b wb_tag=%h, required 1 040", lastSawWb, lastWbTag);
      end
   endtask

   task automatic test_reset_mid_fill();
      bit seen;
      seen      = 1'b0;
      mem_read  = 1'b1;
      mem_write = 1'b0;
      mem_tag   = 9'h055;
      mem_set   = 3'd1;
      for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
         @(negedge clk);
         if (pmem_read) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      testsRun++;
      if (!seen) begin
         testsFailed++;
         $display("[TB] FAIL fill_start_timeout: pmem_read never asserted");
      end
      rst       = 1'b1;
      pmem_resp = 1'b1;
      mem_read  = 1'b0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      pmem_resp = 1'b0;
      modelReset();
      @(negedge clk);
      testsRun++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b0 || way_sel !== 4'b0000 || wb_tag !== 9'h000) begin
         testsFailed++;
         $display("[TB] FAIL reset_mid_fill: pr=%0b pw=%0b resp=%0b way=%b wb_tag=%h, required all 0",
                  pmem_read, pmem_write, mem_resp, way_sel, wb_tag);
      end
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 9'h055, 3'd1, 3);
      testsRun++;
      if (lastSawRead !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reread_misses: fill=%0b, required 1", lastSawRead);
      end
   endtask

`ifdef CACHE_PERF_CTR_EN
   task automatic test_perf_counters();
      applyReset();
      for (int t = 0; t < 3; t++) applyStimulus(1'b1, 1'b0, 9'h100 + 9'(t), 3'd0, 2);
      for (int t = 0; t < 2; t++) applyStimulus(1'b1, 1'b0, 9'h100 + 9'(t), 3'd0, 2);
      testsRun++;
      if (hit_count !== 32'(expHits) || miss_count !== 32'(expMisses)) begin
         testsFailed++;
         $display("[TB] FAIL perf_counters: hits=%0d misses=%0d, required %0d %0d",
                  hit_count, miss_count, expHits, expMisses);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clean_fill();
      test_plru_victim();
      test_dirty_writeback();
      test_read_write_both();
      test_reset_mid_fill();
`ifdef CACHE_PERF_CTR_EN
      test_perf_counters();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
